// File: rtl/rca_seq_adder.sv
// Multi-byte serial adder: one 8-bit ripple-carry adder stepped over NBYTES cycles, LSB byte first.
// Optional subtract mode (extra `sub` port) is enabled by defining RCA_SEQ_SUB_EN.

module rca8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Cout
);
  logic carry;

  always_comb begin
    Sum   = '0;
    carry = Cin;
    for (int i = 0; i < 8; i++) begin
      Sum[i] = A[i] ^ B[i] ^ carry;
      carry  = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    Cout = carry;
  end
endmodule

// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | adding one byte per cycle, idx selects the current byte
// DONE  | result held on sum/cout with out_valid high until out_ready
module rca_seq_adder #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic                sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                busy
);
  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    sum_sh_q, sum_sh_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [IDXW-1:0] idx_q, idx_d;

  logic [W-1:0]    b_in;
  logic            carry_init;
  logic [7:0]      byte_sum;
  logic            byte_cout;
  logic [W+7:0]    sum_cat;

`ifdef RCA_SEQ_SUB_EN
  // Subtract as a + ~b + 1; the inversion is applied once when the operand is latched.
  assign b_in       = sub ? ~b : b;
  assign carry_init = sub ? 1'b1 : cin;
`else
  assign b_in       = b;
  assign carry_init = cin;
`endif

  rca8bit u_rca (
    .A    (a_sh_q[7:0]),
    .B    (b_sh_q[7:0]),
    .Cin  (carry_q),
    .Sum  (byte_sum),
    .Cout (byte_cout)
  );

  // Concatenate then drop the low byte so NBYTES=1 needs no special case.
  assign sum_cat = {byte_sum, sum_sh_q};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b_in;
          carry_d = carry_init;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 8;
        b_sh_d   = b_sh_q >> 8;
        sum_sh_d = sum_cat[W+7:8];
        carry_d  = byte_cout;
        idx_d    = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          sum_d   = sum_cat[W+7:8];
          cout_d  = byte_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      idx_q    <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_rca_seq_adder.sv
// Directed bench for rca_seq_adder: NBYTES=4 and NBYTES=1 instances, vector table plus handshake corner cases.
module tb_rca_seq_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid4 = 1'b0, out_ready4 = 1'b1, cin4 = 1'b0;
  logic        in_ready4, out_valid4, cout4, busy4;
  logic [31:0] a4 = '0, b4 = '0, sum4;

  logic        in_valid1 = 1'b0, out_ready1 = 1'b1, cin1 = 1'b0;
  logic        in_ready1, out_valid1, cout1, busy1;
  logic [7:0]  a1 = '0, b1 = '0, sum1;
`ifdef RCA_SEQ_SUB_EN
  logic        sub4 = 1'b0, sub1 = 1'b0;
`endif

  rca_seq_adder #(.NBYTES(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4),
`ifdef RCA_SEQ_SUB_EN
    .sub(sub4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4), .busy(busy4)
  );

  rca_seq_adder #(.NBYTES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
`ifdef RCA_SEQ_SUB_EN
    .sub(sub1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1), .busy(busy1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sb;
    logic [31:0] s;
    logic        c;
  } vec_t;

  vec_t vecs[8];
  int   n_vec;

  // Applies one operand pair to the 4-byte instance; returns result and accept-to-valid edge count.
  task automatic op4(input logic [31:0] a, input logic [31:0] b, input logic c_in, input logic sb,
                     output logic [31:0] s, output logic c, output int lat);
    a4 = a; b4 = b; cin4 = c_in; in_valid4 = 1'b1; out_ready4 = 1'b1;
`ifdef RCA_SEQ_SUB_EN
    sub4 = sb;
`else
    if (sb) $display("sub vector skipped without subtract mode");
`endif
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sum4;
    c = cout4;
  endtask

  logic [31:0] rs;
  logic        rc;
  int          lat;
  int          n;
  logic        seen_low;

  initial begin
    n_vec = 0;
    vecs[n_vec++] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0};
    vecs[n_vec++] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[n_vec++] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0};
    vecs[n_vec++] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
    vecs[n_vec++] = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0};
    vecs[n_vec++] = '{32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, 32'hEFBE_D000, 1'b0};
`ifdef RCA_SEQ_SUB_EN
    vecs[n_vec++] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0};
    vecs[n_vec++] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1};
`endif

    #12 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_in_ready", in_ready4, 1);
    chk("reset_out_valid", out_valid4, 0);
    chk("reset_sum", sum4, 0);
    chk("reset_cout", cout4, 0);
    chk("reset_busy", busy4, 0);

    for (int i = 0; i < n_vec; i++) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sb, rs, rc, lat);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_sum", i), rs, vecs[i].s);
      chk($sformatf("vec%0d_cout", i), rc, vecs[i].c);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid_pulse", i), out_valid4, 0);
    end

    // Hold in DONE with out_ready low while a new request waits.
    a4 = 32'h1234_5678; b4 = 32'h8765_4321; cin4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b0;
`ifdef RCA_SEQ_SUB_EN
    sub4 = 1'b0;
`endif
    @(posedge clk); #1;
    a4 = 32'h0000_0001; b4 = 32'h0000_0002;
    lat = 0;
    while (!out_valid4 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_latency", lat, 4);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_valid", k), out_valid4, 1);
      chk($sformatf("hold%0d_sum", k), sum4, 32'h9999_9999);
      chk($sformatf("hold%0d_cout", k), cout4, 0);
      chk($sformatf("hold%0d_in_ready", k), in_ready4, 0);
    end
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    chk("release_valid_low", out_valid4, 0);
    chk("release_not_accepted", busy4, 0);
    @(posedge clk); #1;
    chk("next_accepted", busy4, 1);
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("next_latency", lat, 4);
    chk("next_sum", sum4, 32'h0000_0003);
    @(posedge clk); #1;

    // Back-to-back spacing with in_valid and out_ready held high.
    a4 = 32'h0000_0010; b4 = 32'h0000_0020; in_valid4 = 1'b1; out_ready4 = 1'b1;
    @(posedge clk); #1;
    n = 0; seen_low = 1'b0;
    while (!(seen_low && busy4) && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!busy4) seen_low = 1'b1;
    end
    chk("throughput_period", n, 6);
    in_valid4 = 1'b0;
    n = 0;
    while (busy4 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_idle", busy4, 0);
    chk("throughput_sum", sum4, 32'h0000_0030);

    // Reset while RUN is at idx=2.
    a4 = 32'hFFFF_FFFF; b4 = 32'h0000_0001; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_busy", busy4, 1);
    rst = 1'b1;
    #2;
    chk("midrst_out_valid", out_valid4, 0);
    chk("midrst_sum", sum4, 0);
    chk("midrst_busy", busy4, 0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready4, 1);
    op4(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, rs, rc, lat);
    chk("post_reset_sum", rs, 32'h0000_0007);
    chk("post_reset_cout", rc, 0);
    chk("post_reset_latency", lat, 4);

    // Single-byte instance.
    a1 = 8'hF0; b1 = 8'h20; cin1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("nb1_latency", lat, 1);
    chk("nb1_sum", sum1, 8'h11);
    chk("nb1_cout", cout1, 1);
    @(posedge clk); #1;
    a1 = 8'h7F; b1 = 8'h01; cin1 = 1'b0; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("nb1b_latency", lat, 1);
    chk("nb1b_sum", sum1, 8'h80);
    chk("nb1b_cout", cout1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
